// File: rtl/ctrl_pipe_seq.sv
// Control pipeline carrying the decoded word through NUM_STAGES registers,
// with a beat sequencer that replays vector ops and a pair of saturating PMC counters.
module ctrl_pipe_seq #(
  parameter int CTRL_W     = 25,
  parameter int NUM_STAGES = 3,
  parameter int VLEN       = 16,
  parameter int BEAT_LANES = 4,
  localparam int BEATS     = VLEN / BEAT_LANES,
  localparam int BW        = ($clog2(BEATS) < 1) ? 1 : $clog2(BEATS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CTRL_W-1:0]            ctrlD,
  input  logic                         validD,
  input  logic                         vecD,
  input  logic [NUM_STAGES-1:0]        stall_in,
  input  logic [NUM_STAGES-1:0]        flush_in,
  input  logic                         pmc_en,
  output logic [NUM_STAGES*CTRL_W-1:0] ctrl_out,
  output logic [NUM_STAGES-1:0]        valid_out,
  output logic [NUM_STAGES*BW-1:0]     beat_out,
  output logic [NUM_STAGES-1:0]        last_out,
  output logic                         stallD,
  output logic                         busy,
  output logic [31:0]                  instr_cnt,
  output logic [31:0]                  stall_cnt
);

  localparam bit MULTI = (BEATS > 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam int LAST_STG = NUM_STAGES - 1;

  if (((VLEN % BEAT_LANES) != 0) || (NUM_STAGES < 1)) begin : g_paramCheck
    $error("ctrl_pipe_seq: VLEN must be a multiple of BEAT_LANES and NUM_STAGES >= 1");
  end

  typedef enum logic {IDLE, SEQ} state_t;

  state_t                               state_q, state_d;
  logic [BW-1:0]                        beatCnt_q, beatCnt_d;
  logic [CTRL_W-1:0]                    hold_q, hold_d;
  logic [NUM_STAGES-1:0][CTRL_W-1:0]    ctrl_q;
  logic [NUM_STAGES-1:0][BW-1:0]        beat_q;
  logic [NUM_STAGES-1:0]                valid_q;
  logic [NUM_STAGES-1:0]                last_q;
  logic [31:0]                          instrCnt_q;
  logic [31:0]                          stallCnt_q;

  logic [CTRL_W-1:0] issueCtrl;
  logic [BW-1:0]     issueBeat;
  logic              issueValid;
  logic              issueLast;
  logic              stallRaw;

  logic [CTRL_W-1:0] srcCtrl  [NUM_STAGES];
  logic [BW-1:0]     srcBeat  [NUM_STAGES];
  logic              srcValid [NUM_STAGES];
  logic              srcLast  [NUM_STAGES];

  // Sequencer: picks the word offered to stage 0 and decides whether decode must hold.
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    hold_d     = hold_q;
    issueCtrl  = ctrlD;
    issueBeat  = '0;
    issueValid = validD;
    issueLast  = ~(vecD & MULTI);
    stallRaw   = 1'b0;
    case (state_q)
      IDLE: begin
        if (validD & vecD & MULTI) begin
          stallRaw = 1'b1;
          if (~stall_in[0] & ~flush_in[0]) begin
            hold_d    = ctrlD;
            beatCnt_d = BW'(1);
            state_d   = SEQ;
          end
        end
      end
      SEQ: begin
        issueCtrl  = hold_q;
        issueBeat  = beatCnt_q;
        issueValid = 1'b1;
        issueLast  = (beatCnt_q == LAST_BEAT);
        stallRaw   = ~(issueLast & ~stall_in[0]);
        if (flush_in[0]) begin
          state_d   = IDLE;
          beatCnt_d = '0;
        end else if (~stall_in[0]) begin
          if (issueLast) begin
            state_d   = IDLE;
            beatCnt_d = '0;
          end else begin
            beatCnt_d = beatCnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      hold_q    <= hold_d;
    end
  end

  // A stalled upstream stage (or no valid issue at stage 0) hands a bubble downstream.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_src
    if (i == 0) begin : g_first
      assign srcCtrl[i]  = issueValid ? issueCtrl : '0;
      assign srcBeat[i]  = issueValid ? issueBeat : '0;
      assign srcValid[i] = issueValid;
      assign srcLast[i]  = issueValid & issueLast;
    end else begin : g_next
      assign srcCtrl[i]  = stall_in[i-1] ? '0 : ctrl_q[i-1];
      assign srcBeat[i]  = stall_in[i-1] ? '0 : beat_q[i-1];
      assign srcValid[i] = ~stall_in[i-1] & valid_q[i-1];
      assign srcLast[i]  = ~stall_in[i-1] & last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      beat_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (flush_in[i]) begin
          ctrl_q[i]  <= '0;
          beat_q[i]  <= '0;
          valid_q[i] <= 1'b0;
          last_q[i]  <= 1'b0;
        end else if (!stall_in[i]) begin
          ctrl_q[i]  <= srcCtrl[i];
          beat_q[i]  <= srcBeat[i];
          valid_q[i] <= srcValid[i];
          last_q[i]  <= srcLast[i];
        end
      end
    end
  end

  // Retire counts only the final beat leaving the last stage; both counters saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrCnt_q <= '0;
      stallCnt_q <= '0;
    end else if (pmc_en) begin
      if (valid_q[LAST_STG] & last_q[LAST_STG] & ~stall_in[LAST_STG] & ~flush_in[LAST_STG]
          & (instrCnt_q != 32'hFFFF_FFFF))
        instrCnt_q <= instrCnt_q + 32'd1;
      if (stallD & (stallCnt_q != 32'hFFFF_FFFF))
        stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stallD    = reset & stallRaw;
  assign busy      = (state_q == SEQ);
  assign ctrl_out  = ctrl_q;
  assign beat_out  = beat_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign instr_cnt = instrCnt_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// Directed bench for ctrl_pipe_seq: a table of per-cycle vectors for scalar/vector/PMC
// behaviour, then hand sequences for stall, flush and asynchronous reset corners.
module tb_ctrl_pipe_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] ctrlD;
  logic        validD, vecD, pmc_en;
  logic [2:0]  stall_in, flush_in;
  logic [74:0] ctrl_out;
  logic [2:0]  valid_out, last_out;
  logic [5:0]  beat_out;
  logic        stallD, busy;
  logic [31:0] instr_cnt, stall_cnt;

  int   totalChecks = 0;
  int   badChecks   = 0;
  logic preStallD;

  localparam logic [24:0] A = 25'h00AAAAA, B = 25'h00BBBBB, C = 25'h00CCCCC;
  localparam logic [24:0] V = 25'h01F0F0F, S = 25'h0055555, W = 25'h0123456;
  localparam logic [24:0] T = 25'h00ABCDE, X = 25'h1E00001;

  typedef struct {
    logic [24:0] ctrl;
    logic        valid, vec, pmc;
    logic        expStallD;
    logic [24:0] expC0;
    logic        expV0;
    logic [1:0]  expB0;
    logic        expL0;
    logic [24:0] expC2;
    logic        expV2;
    logic [1:0]  expB2;
    logic        expL2;
    logic        expBusy;
    int          expInstr, expScnt;
  } vec_t;

  vec_t vecs [23];

  ctrl_pipe_seq dut (
    .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD), .vecD(vecD),
    .stall_in(stall_in), .flush_in(flush_in), .pmc_en(pmc_en),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .beat_out(beat_out), .last_out(last_out),
    .stallD(stallD), .busy(busy), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, capture the combinational stallD, then step past the edge.
  task automatic applyStimulus(input logic [24:0] c, input logic v, input logic vc,
                               input logic [2:0] st, input logic [2:0] fl, input logic pe);
    ctrlD = c; validD = v; vecD = vc; stall_in = st; flush_in = fl; pmc_en = pe;
    #1;
    preStallD = stallD;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkStage(input string tag, input int s, input logic [24:0] c,
                            input logic v, input logic [1:0] b, input logic l);
    checkOutput({tag, " ctrl"},  64'(ctrl_out[s*25 +: 25]), 64'(c));
    checkOutput({tag, " valid"}, 64'(valid_out[s]), 64'(v));
    checkOutput({tag, " beat"},  64'(beat_out[s*2 +: 2]), 64'(b));
    checkOutput({tag, " last"},  64'(last_out[s]), 64'(l));
  endtask

  initial begin
    vecs[0]  = '{A,1,0,1, 0, A,1,0,1, 0,0,0,0, 0, 0,0};
    vecs[1]  = '{B,1,0,1, 0, B,1,0,1, 0,0,0,0, 0, 0,0};
    vecs[2]  = '{C,1,0,1, 0, C,1,0,1, A,1,0,1, 0, 0,0};
    vecs[3]  = '{0,0,0,1, 0, 0,0,0,0, B,1,0,1, 0, 1,0};
    vecs[4]  = '{0,0,0,1, 0, 0,0,0,0, C,1,0,1, 0, 2,0};
    vecs[5]  = '{0,0,0,1, 0, 0,0,0,0, 0,0,0,0, 0, 3,0};
    vecs[6]  = '{V,1,1,1, 1, V,1,0,0, 0,0,0,0, 1, 3,1};
    vecs[7]  = '{V,1,1,1, 1, V,1,1,0, 0,0,0,0, 1, 3,2};
    vecs[8]  = '{V,1,1,1, 1, V,1,2,0, V,1,0,0, 1, 3,3};
    vecs[9]  = '{V,1,1,1, 0, V,1,3,1, V,1,1,0, 0, 3,3};
    vecs[10] = '{S,1,0,1, 0, S,1,0,1, V,1,2,0, 0, 3,3};
    vecs[11] = '{0,0,0,1, 0, 0,0,0,0, V,1,3,1, 0, 3,3};
    vecs[12] = '{0,0,0,1, 0, 0,0,0,0, S,1,0,1, 0, 4,3};
    vecs[13] = '{0,0,0,1, 0, 0,0,0,0, 0,0,0,0, 0, 5,3};
    vecs[14] = '{W,1,1,0, 1, W,1,0,0, 0,0,0,0, 1, 5,3};
    vecs[15] = '{W,1,1,0, 1, W,1,1,0, 0,0,0,0, 1, 5,3};
    vecs[16] = '{W,1,1,0, 1, W,1,2,0, W,1,0,0, 1, 5,3};
    vecs[17] = '{W,1,1,0, 0, W,1,3,1, W,1,1,0, 0, 5,3};
    vecs[18] = '{T,1,0,0, 0, T,1,0,1, W,1,2,0, 0, 5,3};
    vecs[19] = '{0,0,0,0, 0, 0,0,0,0, W,1,3,1, 0, 5,3};
    vecs[20] = '{0,0,0,0, 0, 0,0,0,0, T,1,0,1, 0, 5,3};
    vecs[21] = '{0,0,0,0, 0, 0,0,0,0, 0,0,0,0, 0, 5,3};
    vecs[22] = '{0,0,0,1, 0, 0,0,0,0, 0,0,0,0, 0, 5,3};

    reset = 1'b0; ctrlD = '0; validD = 0; vecD = 0;
    stall_in = '0; flush_in = '0; pmc_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid_out", 64'(valid_out), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset instr_cnt", 64'(instr_cnt), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].valid, vecs[i].vec, 3'b000, 3'b000, vecs[i].pmc);
      checkOutput($sformatf("row%0d stallD", i), 64'(preStallD), 64'(vecs[i].expStallD));
      checkStage($sformatf("row%0d s0", i), 0, vecs[i].expC0, vecs[i].expV0,
                 vecs[i].expB0, vecs[i].expL0);
      checkStage($sformatf("row%0d s2", i), 2, vecs[i].expC2, vecs[i].expV2,
                 vecs[i].expB2, vecs[i].expL2);
      checkOutput($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d instr_cnt", i), 64'(instr_cnt), 64'(vecs[i].expInstr));
      checkOutput($sformatf("row%0d stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].expScnt));
    end

    // Stage-0 stall for two cycles while stage 0 holds beat 1.
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkStage("st1 s0", 0, V, 1, 2'd0, 0);
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkStage("st2 s0", 0, V, 1, 2'd1, 0);
    applyStimulus(V, 1, 1, 3'b001, 3'b000, 1);
    checkOutput("st3 stallD", 64'(preStallD), 64'd1);
    checkStage("st3 s0", 0, V, 1, 2'd1, 0);
    checkOutput("st3 s1 valid", 64'(valid_out[1]), 64'd0);
    checkStage("st3 s2", 2, V, 1, 2'd0, 0);
    applyStimulus(V, 1, 1, 3'b001, 3'b000, 1);
    checkStage("st4 s0", 0, V, 1, 2'd1, 0);
    checkOutput("st4 s1 valid", 64'(valid_out[1]), 64'd0);
    checkOutput("st4 s2 valid", 64'(valid_out[2]), 64'd0);
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkOutput("st5 stallD", 64'(preStallD), 64'd1);
    checkStage("st5 s0", 0, V, 1, 2'd2, 0);
    checkStage("st5 s1", 1, V, 1, 2'd1, 0);
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkOutput("st6 stallD", 64'(preStallD), 64'd0);
    checkStage("st6 s0", 0, V, 1, 2'd3, 1);
    checkOutput("st6 busy", 64'(busy), 64'd0);
    checkOutput("st6 stall_cnt", 64'(stall_cnt), 64'd8);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("st8 instr_cnt", 64'(instr_cnt), 64'd5);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("st9 instr_cnt", 64'(instr_cnt), 64'd6);

    // Flush of stage 0 while beat 2 is being offered aborts the vector.
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkStage("fl2 s0", 0, V, 1, 2'd1, 0);
    applyStimulus(V, 1, 1, 3'b000, 3'b001, 1);
    checkOutput("fl3 stallD", 64'(preStallD), 64'd1);
    checkStage("fl3 s0", 0, 25'd0, 0, 2'd0, 0);
    checkStage("fl3 s1", 1, V, 1, 2'd1, 0);
    checkOutput("fl3 busy", 64'(busy), 64'd0);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("fl4 stallD", 64'(preStallD), 64'd0);
    checkOutput("fl4 s0 valid", 64'(valid_out[0]), 64'd0);
    checkStage("fl4 s2", 2, V, 1, 2'd1, 0);
    checkOutput("fl4 stall_cnt", 64'(stall_cnt), 64'd11);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("fl5 s2 valid", 64'(valid_out[2]), 64'd0);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("fl7 valid_out", 64'(valid_out), 64'd0);
    checkOutput("fl7 instr_cnt", 64'(instr_cnt), 64'd6);

    // Asynchronous reset in the middle of a vector sequence.
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    applyStimulus(V, 1, 1, 3'b000, 3'b000, 1);
    checkStage("rs2 s0", 0, V, 1, 2'd1, 0);
    checkOutput("rs2 busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("rs ctrl_out", 64'(ctrl_out), 64'd0);
    checkOutput("rs valid_out", 64'(valid_out), 64'd0);
    checkOutput("rs beat_out", 64'(beat_out), 64'd0);
    checkOutput("rs last_out", 64'(last_out), 64'd0);
    checkOutput("rs stallD", 64'(stallD), 64'd0);
    checkOutput("rs busy", 64'(busy), 64'd0);
    checkOutput("rs instr_cnt", 64'(instr_cnt), 64'd0);
    checkOutput("rs stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(X, 1, 0, 3'b000, 3'b000, 1);
    checkOutput("rx stallD", 64'(preStallD), 64'd0);
    checkStage("rx s0", 0, X, 1, 2'd0, 1);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkStage("rx s2", 2, X, 1, 2'd0, 1);
    applyStimulus(0, 0, 0, 3'b000, 3'b000, 1);
    checkOutput("rx instr_cnt", 64'(instr_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
